// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 raster timing with pixel-rate divider.
// Drives hsync/vsync and pixel_x/pixel_y/video_on for the pixel generator.
//
// Ports:
//   clk, reset     : system clock, synchronous active-high reset
//   p_tick         : pixel-rate enable, one clk wide
//   pixel_x/y      : raster counters (10 bit)
//   video_on       : high in the visible region
//   hsync/vsync    : active-low registered sync pulses
//   frame_tick     : one-clk pulse on the first pixel of a frame
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_RETRACE = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_RETRACE = 2,
  parameter int V_BACK    = 33,
  parameter int TICK_DIV  = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int H_TOTAL =
    H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
  localparam int V_TOTAL =
    V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;

  localparam int DW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS = 10'(V_DISPLAY);
  localparam logic [9:0] HS_LO = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_HI =
    10'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
  localparam logic [9:0] VS_LO = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_HI =
    10'(V_DISPLAY + V_FRONT + V_RETRACE - 1);

  logic [DW-1:0] div_cnt;
  logic [9:0]    x_next;
  logic [9:0]    y_next;
  logic          h_end;
  logic          v_end;

  // Gated by reset so a divide-by-1 build still shows p_tick=0 in reset.
  assign p_tick = !reset && (div_cnt == DIV_MAX);

  always_comb begin
    h_end  = (pixel_x == H_MAX);
    v_end  = (pixel_y == V_MAX);
    x_next = pixel_x;
    y_next = pixel_y;
    if (p_tick) begin
      x_next = h_end ? '0 : pixel_x + 10'd1;
      if (h_end)
        y_next = v_end ? '0 : pixel_y + 10'd1;
    end
  end

  // Syncs load from the next count so they line up with the
  // counter registers in the same clk cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      pixel_x <= '0;
      pixel_y <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else begin
      if (div_cnt == DIV_MAX)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + 1'b1;
      pixel_x <= x_next;
      pixel_y <= y_next;
      hsync   <= !((x_next >= HS_LO) && (x_next <= HS_HI));
      vsync   <= !((y_next >= VS_LO) && (y_next <= VS_HI));
    end
  end

  assign video_on   = (pixel_x < H_VIS) && (pixel_y < V_VIS);
  assign frame_tick = p_tick && (pixel_x == '0) && (pixel_y == '0);

  a_geom: assert property (@(posedge clk)
    (H_TOTAL <= 1024) && (V_TOTAL <= 1024) && (TICK_DIV >= 1));

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized and directed checks of vga_sync_gen
// against a closed-form raster model.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       ft;
  } obs_t;

  localparam obs_t RST = '{1'b0, 10'd0, 10'd0,
                           1'b1, 1'b1, 1'b1, 1'b0};

  // dut_b: shrunk raster, divide by 3
  localparam int BHD = 20, BHF = 4, BHR = 6, BHB = 5;
  localparam int BVD = 12, BVF = 3, BVR = 2, BVB = 4;
  localparam int BD  = 3;
  localparam int BFRAME = 35 * 21 * 3;
  // dut_c: full-width lines, short frame, divide by 1
  localparam int CVD = 8, CVF = 2, CVR = 2, CVB = 1;
  localparam int CFRAME = 800 * 13;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  always #5 clk = ~clk;

  logic       tk_a, tk_b, tk_c;
  logic [9:0] x_a, x_b, x_c, y_a, y_b, y_c;
  logic       vo_a, vo_b, vo_c, hs_a, hs_b, hs_c;
  logic       vs_a, vs_b, vs_c, ft_a, ft_b, ft_c;
  obs_t       obs_a, obs_b, obs_c;

  assign obs_a = {tk_a, x_a, y_a, vo_a, hs_a, vs_a, ft_a};
  assign obs_b = {tk_b, x_b, y_b, vo_b, hs_b, vs_b, ft_b};
  assign obs_c = {tk_c, x_c, y_c, vo_c, hs_c, vs_c, ft_c};

  vga_sync_gen dut_a (
    .clk(clk), .reset(rst_a), .p_tick(tk_a),
    .pixel_x(x_a), .pixel_y(y_a), .video_on(vo_a),
    .hsync(hs_a), .vsync(vs_a), .frame_tick(ft_a));

  vga_sync_gen #(
    .H_DISPLAY(BHD), .H_FRONT(BHF), .H_RETRACE(BHR),
    .H_BACK(BHB), .V_DISPLAY(BVD), .V_FRONT(BVF),
    .V_RETRACE(BVR), .V_BACK(BVB), .TICK_DIV(BD)
  ) dut_b (
    .clk(clk), .reset(rst_b), .p_tick(tk_b),
    .pixel_x(x_b), .pixel_y(y_b), .video_on(vo_b),
    .hsync(hs_b), .vsync(vs_b), .frame_tick(ft_b));

  vga_sync_gen #(
    .V_DISPLAY(CVD), .V_FRONT(CVF), .V_RETRACE(CVR),
    .V_BACK(CVB), .TICK_DIV(1)
  ) dut_c (
    .clk(clk), .reset(rst_c), .p_tick(tk_c),
    .pixel_x(x_c), .pixel_y(y_c), .video_on(vo_c),
    .hsync(hs_c), .vsync(vs_c), .frame_tick(ft_c));

  int checks = 0;
  int errors = 0;
  int ca, cb, cc;

  // c = clk edges since reset was released.
  // Pixels consumed = c / d; position follows from that directly.
  function automatic obs_t model(int c, int d,
    int hd, int hf, int hr, int hb,
    int vd, int vf, int vr, int vb);
    obs_t m;
    int ht, vt, p, x, y;
    ht = hd + hf + hr + hb;
    vt = vd + vf + vr + vb;
    p  = (c / d) % (ht * vt);
    x  = p % ht;
    y  = p / ht;
    m.tick = ((c % d) == d - 1);
    m.x    = 10'(x);
    m.y    = 10'(y);
    m.von  = (x < hd) && (y < vd);
    m.hs   = !((x >= hd + hf) && (x < hd + hf + hr));
    m.vs   = !((y >= vd + vf) && (y < vd + vf + vr));
    m.ft   = m.tick && (x == 0) && (y == 0);
    return m;
  endfunction

  function automatic obs_t model_a(int c);
    return model(c, 2, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic obs_t model_b(int c);
    return model(c, BD, BHD, BHF, BHR, BHB,
                 BVD, BVF, BVR, BVB);
  endfunction

  function automatic obs_t model_c(int c);
    return model(c, 1, 640, 16, 96, 48,
                 CVD, CVF, CVR, CVB);
  endfunction

  task automatic test_reset();
    int first;
    rst_a = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (obs_a !== RST) begin
        errors++;
        $display("FAIL reset_hold got=%h exp=%h", obs_a, RST);
      end
    end
    rst_a = 1'b0; #1;
    ca = 0;
    first = -1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin @(posedge clk); #1; ca++; end
      checks++;
      if (obs_a !== model_a(ca)) begin
        errors++;
        $display("FAIL after_release c=%0d got=%h exp=%h",
                 ca, obs_a, model_a(ca));
      end
      if (first < 0 && obs_a.tick) first = ca;
    end
    checks++;
    if (first !== 1) begin
      errors++;
      $display("FAIL first_tick got=%0d exp=1", first);
    end
  endtask

  task automatic test_line();
    obs_t prev;
    int fall_x, fall_px, wrap_c, wrap_y;
    fall_x = -1; fall_px = -1; wrap_c = -1; wrap_y = -1;
    prev = obs_a;
    repeat (1700) begin
      @(posedge clk); #1; ca++;
      checks++;
      if (obs_a !== model_a(ca)) begin
        errors++;
        $display("FAIL line c=%0d got=%h exp=%h",
                 ca, obs_a, model_a(ca));
      end
      if (prev.von && !obs_a.von && fall_x < 0) begin
        fall_x  = int'(obs_a.x);
        fall_px = int'(prev.x);
      end
      if (prev.x == 10'd799 && obs_a.x == 10'd0 && wrap_c < 0) begin
        wrap_c = ca;
        wrap_y = int'(obs_a.y);
      end
      prev = obs_a;
    end
    checks++;
    if (fall_x !== 640 || fall_px !== 639) begin
      errors++;
      $display("FAIL video_off x=%0d prev=%0d exp=640/639",
               fall_x, fall_px);
    end
    checks++;
    if (wrap_c !== 1600) begin
      errors++;
      $display("FAIL line_period got=%0d exp=1600", wrap_c);
    end
    checks++;
    if (wrap_y !== 1) begin
      errors++;
      $display("FAIL line_y got=%0d exp=1", wrap_y);
    end
  endtask

  task automatic test_hsync();
    obs_t prev;
    int fall_c, fall_x, rise_c, rise_x, low_ticks;
    fall_c = -1; fall_x = -1; rise_c = -1; rise_x = -1;
    low_ticks = 0;
    prev = obs_a;
    repeat (2000) begin
      @(posedge clk); #1; ca++;
      checks++;
      if (obs_a !== model_a(ca)) begin
        errors++;
        $display("FAIL hsync_run c=%0d got=%h exp=%h",
                 ca, obs_a, model_a(ca));
      end
      if (prev.hs && !obs_a.hs && fall_c < 0) begin
        fall_c = ca;
        fall_x = int'(obs_a.x);
      end
      if (fall_c >= 0 && rise_c < 0) begin
        if (!prev.hs && obs_a.hs) begin
          rise_c = ca;
          rise_x = int'(obs_a.x);
        end else if (!obs_a.hs && obs_a.tick) begin
          low_ticks++;
        end
      end
      prev = obs_a;
    end
    checks++;
    if (fall_x !== 656 || rise_x !== 752) begin
      errors++;
      $display("FAIL hsync_edges fall_x=%0d rise_x=%0d exp=656/752",
               fall_x, rise_x);
    end
    checks++;
    if (rise_c - fall_c !== 192 || fall_c < 0) begin
      errors++;
      $display("FAIL hsync_width got=%0d exp=192",
               rise_c - fall_c);
    end
    checks++;
    if (low_ticks !== 96) begin
      errors++;
      $display("FAIL hsync_ticks got=%0d exp=96", low_ticks);
    end
  endtask

  task automatic test_frame();
    obs_t prev;
    int ft_q[$];
    int vfall_c, vfall_y, vrise_c;
    vfall_c = -1; vfall_y = -1; vrise_c = -1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0; #1;
    cb = 0;
    prev = obs_b;
    for (int i = 0; i < 3 * BFRAME + 20; i++) begin
      if (i > 0) begin @(posedge clk); #1; cb++; end
      checks++;
      if (obs_b !== model_b(cb)) begin
        errors++;
        $display("FAIL frame c=%0d got=%h exp=%h",
                 cb, obs_b, model_b(cb));
      end
      if (obs_b.ft) ft_q.push_back(cb);
      if (prev.vs && !obs_b.vs && vfall_c < 0) begin
        vfall_c = cb;
        vfall_y = int'(obs_b.y);
      end
      if (vfall_c >= 0 && vrise_c < 0 && !prev.vs && obs_b.vs)
        vrise_c = cb;
      prev = obs_b;
    end
    checks++;
    if (ft_q.size() < 3) begin
      errors++;
      $display("FAIL frame_count got=%0d exp>=3", ft_q.size());
    end else begin
      checks++;
      if (ft_q[0] !== BD - 1) begin
        errors++;
        $display("FAIL first_frame got=%0d exp=%0d", ft_q[0], BD - 1);
      end
      for (int k = 1; k < ft_q.size(); k++) begin
        checks++;
        if (ft_q[k] - ft_q[k-1] !== BFRAME) begin
          errors++;
          $display("FAIL frame_period got=%0d exp=%0d",
                   ft_q[k] - ft_q[k-1], BFRAME);
        end
      end
    end
    checks++;
    if (vfall_y !== BVD + BVF) begin
      errors++;
      $display("FAIL vsync_start y=%0d exp=%0d", vfall_y, BVD + BVF);
    end
    checks++;
    if (vrise_c - vfall_c !== BVR * 35 * BD || vrise_c < 0) begin
      errors++;
      $display("FAIL vsync_width got=%0d exp=%0d",
               vrise_c - vfall_c, BVR * 35 * BD);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    bit found;
    n = 0;
    found = 0;
    while (!found && n < 3000) begin
      @(posedge clk); #1; cb++; n++;
      checks++;
      if (obs_b !== model_b(cb)) begin
        errors++;
        $display("FAIL mid_run c=%0d got=%h exp=%h",
                 cb, obs_b, model_b(cb));
      end
      if (obs_b.x == 10'd26 && obs_b.y == 10'd16) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reach got=%0d/%0d exp=26/16",
               obs_b.x, obs_b.y);
    end
    checks++;
    if ({obs_b.hs, obs_b.vs} !== 2'b00) begin
      errors++;
      $display("FAIL mid_syncs got=%b exp=00", {obs_b.hs, obs_b.vs});
    end
    rst_b = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs_b !== RST) begin
      errors++;
      $display("FAIL mid_reset got=%h exp=%h", obs_b, RST);
    end
    rst_b = 1'b0; #1;
    cb = 0;
    checks++;
    if (obs_b !== model_b(0)) begin
      errors++;
      $display("FAIL mid_release got=%h exp=%h", obs_b, model_b(0));
    end
  endtask

  task automatic test_random_reset();
    int n, r;
    for (int it = 0; it < 20; it++) begin
      n = int'($urandom_range(1, 700));
      repeat (n) begin
        @(posedge clk); #1; cb++;
        checks++;
        if (obs_b !== model_b(cb)) begin
          errors++;
          $display("FAIL rnd_run it=%0d c=%0d got=%h exp=%h",
                   it, cb, obs_b, model_b(cb));
        end
      end
      r = int'($urandom_range(1, 3));
      rst_b = 1'b1;
      repeat (r) begin
        @(posedge clk); #1;
        checks++;
        if (obs_b !== RST) begin
          errors++;
          $display("FAIL rnd_reset it=%0d got=%h exp=%h",
                   it, obs_b, RST);
        end
      end
      rst_b = 1'b0; #1;
      cb = 0;
    end
  endtask

  task automatic test_div1();
    obs_t prev;
    int ft_q[$];
    int wrap_c, bad_tick;
    wrap_c = -1;
    bad_tick = 0;
    checks++;
    if (obs_c.tick !== 1'b0) begin
      errors++;
      $display("FAIL div1_reset_tick got=%b exp=0", obs_c.tick);
    end
    rst_c = 1'b0; #1;
    cc = 0;
    prev = obs_c;
    for (int i = 0; i < 2 * CFRAME + 10; i++) begin
      if (i > 0) begin @(posedge clk); #1; cc++; end
      checks++;
      if (obs_c !== model_c(cc)) begin
        errors++;
        $display("FAIL div1 c=%0d got=%h exp=%h",
                 cc, obs_c, model_c(cc));
      end
      if (obs_c.tick !== 1'b1) bad_tick++;
      if (obs_c.ft) ft_q.push_back(cc);
      if (prev.x == 10'd799 && obs_c.x == 10'd0 && wrap_c < 0)
        wrap_c = cc;
      prev = obs_c;
    end
    checks++;
    if (bad_tick !== 0) begin
      errors++;
      $display("FAIL div1_tick_low got=%0d exp=0", bad_tick);
    end
    checks++;
    if (wrap_c !== 800) begin
      errors++;
      $display("FAIL div1_line got=%0d exp=800", wrap_c);
    end
    checks++;
    if (ft_q.size() !== 3) begin
      errors++;
      $display("FAIL div1_frames got=%0d exp=3", ft_q.size());
    end else begin
      checks++;
      if (ft_q[0] !== 0) begin
        errors++;
        $display("FAIL div1_first_frame got=%0d exp=0", ft_q[0]);
      end
      for (int k = 1; k < ft_q.size(); k++) begin
        checks++;
        if (ft_q[k] - ft_q[k-1] !== CFRAME) begin
          errors++;
          $display("FAIL div1_frame got=%0d exp=%0d",
                   ft_q[k] - ft_q[k-1], CFRAME);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_hsync();
    test_frame();
    test_mid_reset();
    test_random_reset();
    test_div1();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
